// File: rtl/emcu_apb_timer_if.sv
// APB3 target-side bus bundle between the EMCU expansion port and the timer.
// The EMCU drives the request half of the bundle; the timer drives the response half.
interface emcu_apb_timer_if;
    logic        psel;
    logic        penable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/emcu_apb_timer.sv
// APB3 down-counting timer: prescaler, auto-reload/one-shot, sticky expiry flag, irq and tick pulse.
// Access phase lasts WAIT_STATES+1 cycles (pready registered); writes commit on the completing edge only.
module emcu_apb_timer #(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_i,
    emcu_apb_timer_if.slave  apb,
    output logic             irq,
    output logic             tick_o
);

    localparam logic [31:0] ID_VAL  = 32'h454D_5431;
    localparam logic [3:0]  WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [9:0] IDX_CTRL   = 10'd0;
    localparam logic [9:0] IDX_LOAD   = 10'd1;
    localparam logic [9:0] IDX_VALUE  = 10'd2;
    localparam logic [9:0] IDX_PRESC  = 10'd3;
    localparam logic [9:0] IDX_STATUS = 10'd4;
    localparam logic [9:0] IDX_ID     = 10'd5;

    logic [2:0]             ctrl_q,      ctrl_d;
    logic [CNT_WIDTH-1:0]   load_q,      load_d;
    logic [CNT_WIDTH-1:0]   value_q,     value_d;
    logic [PRESC_WIDTH-1:0] presc_q,     presc_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic                   expired_q,   expired_d;
    logic                   tick_q,      tick_d;
    logic [3:0]             wait_cnt_q,  wait_cnt_d;
    logic                   pready_q,    pready_d;

    logic        setup_ph, access_ph, complete;
    logic [9:0]  idx;
    logic        acc_err, wr_en, rd_en;
    logic        en, step, expiry;
    logic [31:0] rd_word;
    logic        unused_paddr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? wd[8*b +: 8] : cur[8*b +: 8];
        end
        return res;
    endfunction

    assign unused_paddr_bits = ^apb.paddr[1:0];

    assign setup_ph  = apb.psel & ~apb.penable;
    assign access_ph = apb.psel &  apb.penable;
    assign complete  = access_ph & pready_q;
    assign idx       = apb.paddr[11:2];
    // ID is read-only, so a write to it is reported like an unmapped access
    assign acc_err   = (idx > IDX_ID) | ((idx == IDX_ID) & apb.pwrite);
    assign wr_en     = complete &  apb.pwrite & ~acc_err;
    assign rd_en     = complete & ~apb.pwrite & ~acc_err;

    assign en     = ctrl_q[0];
    assign step   = en & (presc_cnt_q == presc_q);
    assign expiry = step & (value_q == '0);

    always_comb begin
        wait_cnt_d = '0;
        pready_d   = 1'b0;
        if (setup_ph) begin
            pready_d = (WAIT_STATES == 0);
        end else if (access_ph && !pready_q) begin
            if (wait_cnt_q == WS_LAST) begin
                pready_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (idx)
            IDX_CTRL:   rd_word = {29'd0, ctrl_q};
            IDX_LOAD:   rd_word = 32'(load_q);
            IDX_VALUE:  rd_word = 32'(value_q);
            IDX_PRESC:  rd_word = 32'(presc_q);
            IDX_STATUS: rd_word = {31'd0, expired_q};
            IDX_ID:     rd_word = ID_VAL;
            default:    rd_word = '0;
        endcase
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        load_d      = load_q;
        value_d     = value_q;
        presc_d     = presc_q;
        expired_d   = expired_q;
        tick_d      = expiry;
        presc_cnt_d = (!en || step) ? '0 : presc_cnt_q + 1'b1;

        if (step) begin
            if (!expiry) begin
                value_d = value_q - 1'b1;
            end else if (ctrl_q[1]) begin
                value_d = load_q;
            end else begin
                ctrl_d[0] = 1'b0;
            end
        end

        // Register writes are applied after the counter update so they win on collision
        if (wr_en) begin
            case (idx)
                IDX_CTRL:   ctrl_d  = merge_bytes(rd_word, apb.pwdata, apb.pstrb)[2:0];
                IDX_LOAD:   load_d  = CNT_WIDTH'(merge_bytes(rd_word, apb.pwdata, apb.pstrb));
                IDX_VALUE:  value_d = CNT_WIDTH'(merge_bytes(rd_word, apb.pwdata, apb.pstrb));
                IDX_PRESC:  presc_d = PRESC_WIDTH'(merge_bytes(rd_word, apb.pwdata, apb.pstrb));
                IDX_STATUS: begin
                    if (apb.pstrb[0] && apb.pwdata[0]) begin
                        expired_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A fresh expiry outranks a same-cycle clear of the sticky flag
        if (expiry) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q      <= '0;
            load_q      <= '0;
            value_q     <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            expired_q   <= 1'b0;
            tick_q      <= 1'b0;
            wait_cnt_q  <= '0;
            pready_q    <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            load_q      <= load_d;
            value_q     <= value_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            expired_q   <= expired_d;
            tick_q      <= tick_d;
            wait_cnt_q  <= wait_cnt_d;
            pready_q    <= pready_d;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = rd_en ? rd_word : 32'd0;
    assign apb.pslverr = complete & acc_err;
    assign irq         = expired_q & ctrl_q[2];
    assign tick_o      = tick_q;

endmodule

// File: tb/tb_emcu_apb_timer.sv
// Randomized scoreboard bench for emcu_apb_timer against a closed-form timing model.
// Expected APB responses and tick cycles are queued at issue time and consumed by a monitor.
module tb_emcu_apb_timer;
    localparam int WS = 2;
    localparam longint PMASK = 64'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq, tick;
    always #5 clk = ~clk;

    emcu_apb_timer_if apb();

    emcu_apb_timer #(.CNT_WIDTH(32), .PRESC_WIDTH(16), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_i(rst), .apb(apb), .irq(irq), .tick_o(tick)
    );

    int checks = 0;
    int errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] dat; logic err; } exp_t;
    exp_t   exp_q[$];
    longint tick_q[$];

    // Model: timer started at edge m_ec from value m_v0; when stopped, m_v0 is the held value
    bit     m_en, m_reload, m_irq_en, m_exp_flag;
    longint m_ec, m_v0, m_load, m_presc, m_flag_edge;

    function automatic longint first_exp();
        return m_ec + (m_v0 + 1) * (m_presc + 1);
    endfunction

    function automatic longint last_exp(input longint c);
        longint f, p;
        if (!m_en) return -1;
        f = first_exp();
        if (c < f) return -1;
        if (!m_reload) return f;
        p = (m_load + 1) * (m_presc + 1);
        return f + ((c - f) / p) * p;
    endfunction

    function automatic longint value_at(input longint c);
        longint s;
        if (!m_en) return m_v0;
        s = (c - m_ec) / (m_presc + 1);
        if (s <= m_v0) return m_v0 - s;
        if (!m_reload) return 0;
        return m_load - ((s - m_v0 - 1) % (m_load + 1));
    endfunction

    function automatic bit en_at(input longint c);
        return m_en && (m_reload || c < first_exp());
    endfunction

    function automatic bit expired_at(input longint c);
        return m_exp_flag || (last_exp(c) > m_flag_edge);
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] cur, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (cur & ~m) | (wd & m);
    endfunction

    function automatic logic [31:0] model_rd(input logic [11:0] a, input longint c);
        case (a[11:2])
            10'd0:   return {29'd0, m_irq_en, m_reload, en_at(c)};
            10'd1:   return 32'(m_load);
            10'd2:   return 32'(value_at(c));
            10'd3:   return 32'(m_presc);
            10'd4:   return {31'd0, expired_at(c)};
            10'd5:   return 32'h454D5431;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_reload = 0; m_irq_en = 0; m_exp_flag = 0;
        m_ec = 0; m_v0 = 0; m_load = 0; m_presc = 0; m_flag_edge = -1;
        tick_q.delete();
        exp_q.delete();
    endtask

    task automatic freeze(input longint w);
        if (m_en) begin
            m_exp_flag  = expired_at(w);
            m_v0        = value_at(w);
            m_flag_edge = w;
            m_en        = 0;
            while (tick_q.size() > 0 && tick_q[$] > w) void'(tick_q.pop_back());
        end
    endtask

    task automatic model_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be, input longint w);
        logic [31:0] nv;
        longint t, p;
        case (a[11:2])
            10'd0: begin
                nv = mrg({29'd0, m_irq_en, m_reload, en_at(w - 1)}, d, be);
                if (en_at(w - 1) && nv[0]) begin
                    m_irq_en = nv[2];
                end else begin
                    freeze(w);
                    m_irq_en = nv[2];
                    m_reload = nv[1];
                    if (nv[0]) begin
                        m_en = 1;
                        m_ec = w;
                        t = first_exp();
                        p = (m_load + 1) * (m_presc + 1);
                        if (!m_reload) tick_q.push_back(t);
                        else while (t <= w + 3000) begin tick_q.push_back(t); t += p; end
                    end
                end
            end
            10'd1: m_load = longint'(mrg(32'(m_load), d, be));
            10'd2: begin freeze(w); m_v0 = longint'(mrg(32'(m_v0), d, be)); end
            10'd3: m_presc = longint'(mrg(32'(m_presc), d, be)) & PMASK;
            10'd4: if (be[0] && d[0]) begin
                m_exp_flag  = (last_exp(w) == w);
                m_flag_edge = w;
            end
            default: ;
        endcase
    endtask

    task automatic xfer(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                        input logic [3:0] be, output longint commit);
        exp_t e;
        int   waits;
        bit   done;
        @(posedge clk); #1;
        apb.psel = 1; apb.penable = 0; apb.paddr = a; apb.pwrite = wr; apb.pwdata = wd; apb.pstrb = be;
        if (wr) begin e.dat = 32'd0; e.err = (a[11:2] >= 10'd5); end
        else    begin e.dat = model_rd(a, cyc + 1 + WS); e.err = (a[11:2] >= 10'd6); end
        exp_q.push_back(e);
        @(posedge clk); #1;
        apb.penable = 1;
        waits = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (apb.pready === 1'b1) done = 1; else waits++;
        end
        checks++;
        if (!done || waits != WS) begin
            errors++;
            $display("FAIL wait_states addr=%h got %0d low cycles (done=%0b) expected %0d", a, waits, done, WS);
        end
        if (!done) void'(exp_q.pop_back());
        @(posedge clk); #1;
        commit = cyc;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        longint w;
        xfer(a, 1'b1, d, be, w);
        model_wr(a, d, be, w);
    endtask

    task automatic rd(input logic [11:0] a);
        longint w;
        xfer(a, 1'b0, 32'd0, 4'd0, w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: APB responses, tick pulses and the irq level, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (apb.psel && apb.penable && apb.pready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL apb_unexpected_completion addr=%h", apb.paddr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (apb.prdata !== e.dat || apb.pslverr !== e.err) begin
                        errors++;
                        $display("FAIL apb_resp addr=%h got prdata=%h pslverr=%b expected prdata=%h pslverr=%b",
                                 apb.paddr, apb.prdata, apb.pslverr, e.dat, e.err);
                    end
                end
            end else begin
                checks++;
                if (apb.prdata !== 32'd0 || apb.pslverr !== 1'b0) begin
                    errors++;
                    $display("FAIL apb_idle_outputs got prdata=%h pslverr=%b expected 0", apb.prdata, apb.pslverr);
                end
            end
            if (tick === 1'b1) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected at cycle %0d", cyc);
                end else if (tick_q[0] != cyc) begin
                    errors++;
                    $display("FAIL tick_time got cycle %0d expected %0d", cyc, tick_q[0]);
                    void'(tick_q.pop_front());
                end else begin
                    void'(tick_q.pop_front());
                end
            end else if (tick_q.size() > 0 && tick_q[0] < cyc) begin
                errors++; checks++;
                $display("FAIL tick_missing expected at cycle %0d", tick_q[0]);
                void'(tick_q.pop_front());
            end
            checks++;
            if (irq !== (expired_at(cyc) && m_irq_en)) begin
                errors++;
                $display("FAIL irq at cycle %0d got %b expected %b", cyc, irq, expired_at(cyc) && m_irq_en);
            end
        end
    end

    initial begin
        longint ec;
        logic [11:0] a;
        int p, l, v;
        bit rl, ie;

        apb.psel = 0; apb.penable = 0; apb.paddr = '0; apb.pwrite = 0; apb.pwdata = '0; apb.pstrb = '0;
        model_reset();
        idle(3);
        chk("reset_outputs", {28'd0, irq, tick, apb.pready, apb.pslverr}, 32'd0);
        chk("reset_prdata", apb.prdata, 32'd0);
        rst = 0;

        for (int i = 0; i < 6; i++) rd(12'(i * 4));

        // Auto-reload, period 4
        wr(12'h00C, 0); wr(12'h004, 3); wr(12'h008, 3); wr(12'h000, 7);
        for (int i = 0; i < 6; i++) begin idle($urandom_range(0, 3)); rd(12'h008); end
        idle(12);
        rd(12'h010);
        wr(12'h000, 6);
        rd(12'h000);

        // One-shot with prescaler
        wr(12'h010, 1); wr(12'h00C, 1); wr(12'h008, 2); wr(12'h000, 5);
        idle(20);
        rd(12'h000); rd(12'h008); rd(12'h010);

        // W1C landing on the same edge as an expiry
        wr(12'h010, 1); wr(12'h004, 19); wr(12'h00C, 0); wr(12'h008, 19);
        wr(12'h000, 7);
        ec = cyc;
        while (cyc < ec + 35) idle(1);
        wr(12'h010, 1);
        @(negedge clk);
        chk("w1c_collision_irq", {31'd0, irq}, 32'd1);
        rd(12'h010);
        wr(12'h000, 4);
        wr(12'h010, 1);
        rd(12'h010);
        @(negedge clk);
        chk("w1c_clear_irq", {31'd0, irq}, 32'd0);

        rd(12'h014); rd(12'h020);

        wr(12'h004, 0); wr(12'h004, 32'hFFFF_FFFF, 4'b0001); rd(12'h004);
        wr(12'h014, 32'h1234_5678); rd(12'h014);

        // Random register traffic with the timer stopped
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: wr(12'h004, $urandom, 4'($urandom_range(0, 15)));
                1: wr(12'h00C, $urandom, 4'($urandom_range(0, 15)));
                2: wr(12'h008, $urandom, 4'($urandom_range(0, 15)));
                3: wr(12'h000, $urandom & 32'hFFFF_FFFE, 4'($urandom_range(0, 15)));
                4: wr(12'h010, $urandom, 4'($urandom_range(0, 15)));
                default: begin a = {10'($urandom_range(5, 1023)), 2'b00}; wr(a, $urandom, 4'($urandom_range(0, 15))); end
            endcase
            rd({10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))});
        end

        // Random timer runs
        for (int r = 0; r < 4; r++) begin
            p = $urandom_range(0, 3); l = $urandom_range(1, 5); v = $urandom_range(0, 6);
            rl = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 1));
            wr(12'h000, 0); wr(12'h00C, 32'(p)); wr(12'h004, 32'(l)); wr(12'h008, 32'(v));
            wr(12'h000, {29'd0, ie, rl, 1'b1});
            repeat (5) begin
                idle($urandom_range(0, 6));
                if ($urandom_range(0, 3) == 0) wr(12'h010, 1);
                else rd({10'($urandom_range(0, 4)), 2'b00});
            end
            wr(12'h000, {29'd0, ie, rl, 1'b0});
            rd(12'h008); rd(12'h010);
        end

        // Reset in the middle of a count
        wr(12'h00C, 0); wr(12'h004, 5); wr(12'h008, 5); wr(12'h000, 7);
        idle(9);
        rst = 1;
        model_reset();
        idle(2);
        @(negedge clk);
        chk("midrun_reset_outputs", {28'd0, irq, tick, apb.pready, apb.pslverr}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        rd(12'h000); rd(12'h008); rd(12'h004); rd(12'h010);

        idle(10);
        chk("pending_ticks", 32'(tick_q.size()), 32'd0);
        chk("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
